// File: rtl/elevator_floor_controller.sv
// Car scheduler for elevator 1: latches floor calls, runs a collective up/down
// sweep, tracks the floor from motor time and times the door dwell.
module elevator_floor_controller #(
    parameter int NUM_FLOORS      = 4,
    parameter int FLOOR_W         = 2,
    parameter int CYCLES_PER_STEP = 960000,
    parameter int STEPS_PER_FLOOR = 50,
    parameter int DOOR_CYCLES     = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [1:0]            elv1_dir,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  door_open,
    output logic                  moving,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam longint unsigned FLR_CYC =
        64'(CYCLES_PER_STEP) * 64'(STEPS_PER_FLOOR);
    localparam int FLR_W =
        ($clog2(FLR_CYC) > 36) ? $clog2(FLR_CYC) : 36;
    localparam int DOOR_W =
        ($clog2(DOOR_CYCLES) < 1) ? 1 : $clog2(DOOR_CYCLES);
    localparam logic [FLR_W-1:0]  FLR_LAST  = FLR_W'(FLR_CYC - 64'd1);
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

    localparam logic [1:0] DIR_UP   = 2'd0;
    localparam logic [1:0] DIR_DN   = 2'd1;
    localparam logic [1:0] DIR_STOP = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            dir_q, dir_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  door_q, door_d;
    logic                  moving_q, moving_d;
    logic                  last_up_q, last_up_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLR_W-1:0]      flr_cnt_q, flr_cnt_d;
    logic [DOOR_W-1:0]     door_cnt_q, door_cnt_d;

    logic [NUM_FLOORS-1:0] latch;
    logic [NUM_FLOORS-1:0] clr;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  up_ok;
    logic                  dn_ok;
    logic                  ahead;
    logic                  go_up;

    function automatic logic any_above(
        input logic [NUM_FLOORS-1:0] p,
        input logic [FLOOR_W-1:0]    f
    );
        any_above = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f) && p[i]) any_above = 1'b1;
        end
    endfunction

    function automatic logic any_below(
        input logic [NUM_FLOORS-1:0] p,
        input logic [FLOOR_W-1:0]    f
    );
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f) && p[i]) any_below = 1'b1;
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        last_up_d  = last_up_q;
        flr_cnt_d  = flr_cnt_q;
        door_cnt_d = door_cnt_q;
        latch      = pending_q | call_req;
        clr        = '0;
        go_up      = 1'b0;
        up_ok      = any_above(pending_q, floor_q);
        dn_ok      = any_below(pending_q, floor_q);
        next_floor = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1)
                                          : floor_q - FLOOR_W'(1);
        ahead      = (state_q == MOVE_UP) ? any_above(pending_q, next_floor)
                                          : any_below(pending_q, next_floor);

        unique case (state_q)
            IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d    = DOOR;
                    door_cnt_d = '0;
                    clr[floor_q] = 1'b1;
                end else if (up_ok || dn_ok) begin
                    // keep sweeping the way we last went while calls lie there
                    go_up     = up_ok && (last_up_q || !dn_ok);
                    state_d   = go_up ? MOVE_UP : MOVE_DOWN;
                    last_up_d = go_up;
                    flr_cnt_d = '0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (flr_cnt_q == FLR_LAST) begin
                    flr_cnt_d = '0;
                    floor_d   = next_floor;
                    if (pending_q[next_floor]) begin
                        state_d    = DOOR;
                        door_cnt_d = '0;
                        clr[next_floor] = 1'b1;
                    end else if (!ahead) begin
                        state_d = IDLE;
                    end
                end else begin
                    flr_cnt_d = flr_cnt_q + FLR_W'(1);
                end
            end
            DOOR: begin
                // a press at this floor while open extends the dwell
                if (latch[floor_q]) begin
                    door_cnt_d = '0;
                    clr[floor_q] = 1'b1;
                end else if (door_cnt_q == DOOR_LAST) begin
                    state_d = IDLE;
                end else begin
                    door_cnt_d = door_cnt_q + DOOR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = latch & ~clr;
        dir_d     = (state_d == MOVE_UP)   ? DIR_UP :
                    (state_d == MOVE_DOWN) ? DIR_DN : DIR_STOP;
        door_d    = (state_d == DOOR);
        moving_d  = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dir_q      <= DIR_STOP;
            floor_q    <= '0;
            door_q     <= 1'b0;
            moving_q   <= 1'b0;
            last_up_q  <= 1'b1;
            pending_q  <= '0;
            flr_cnt_q  <= '0;
            door_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            floor_q    <= floor_d;
            door_q     <= door_d;
            moving_q   <= moving_d;
            last_up_q  <= last_up_d;
            pending_q  <= pending_d;
            flr_cnt_q  <= flr_cnt_d;
            door_cnt_q <= door_cnt_d;
        end
    end

    assign elv1_dir  = dir_q;
    assign cur_floor = floor_q;
    assign door_open = door_q;
    assign moving    = moving_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_floor_controller.sv
// Randomised bench for elevator_floor_controller against a position-based
// model of the car (position counted in cycles of travel).
module tb_elevator_floor_controller;

    localparam int NF   = 4;
    localparam int FPC  = 8;
    localparam int DOOR = 5;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DN   = 2;
    localparam int M_DOOR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] call_req = 4'b0;
    logic [1:0] elv1_dir;
    logic [1:0] cur_floor;
    logic       door_open;
    logic       moving;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int     m_mode;
    int     m_pos;
    int     m_door;
    bit     m_last_up;
    bit [3:0] m_pend;
    int     stop_q[$];

    always #5 clk = ~clk;

    elevator_floor_controller #(
        .NUM_FLOORS(4),
        .FLOOR_W(2),
        .CYCLES_PER_STEP(4),
        .STEPS_PER_FLOOR(2),
        .DOOR_CYCLES(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .call_req(call_req),
        .elv1_dir(elv1_dir),
        .cur_floor(cur_floor),
        .door_open(door_open),
        .moving(moving),
        .pending(pending)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit above(input bit [3:0] p, input int f);
        for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit below(input bit [3:0] p, input int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_floor();
        if (m_mode == M_DN) return (m_pos + FPC - 1) / FPC;
        return m_pos / FPC;
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_pos     = 0;
        m_door    = 0;
        m_last_up = 1'b1;
        m_pend    = 4'b0;
    endtask

    task automatic model_step(input bit [3:0] c);
        bit [3:0] np;
        int f;
        bit up;
        bit dn;
        np = m_pend | c;
        case (m_mode)
            M_IDLE: begin
                f = m_pos / FPC;
                if (m_pend[f]) begin
                    m_mode = M_DOOR;
                    m_door = DOOR;
                    np[f] = 1'b0;
                end else begin
                    up = above(m_pend, f);
                    dn = below(m_pend, f);
                    if (up && (m_last_up || !dn)) begin
                        m_mode = M_UP;
                        m_last_up = 1'b1;
                    end else if (dn) begin
                        m_mode = M_DN;
                        m_last_up = 1'b0;
                    end
                end
            end
            M_UP, M_DN: begin
                m_pos = (m_mode == M_UP) ? m_pos + 1 : m_pos - 1;
                if (m_pos % FPC == 0) begin
                    f = m_pos / FPC;
                    if (m_pend[f]) begin
                        m_mode = M_DOOR;
                        m_door = DOOR;
                        np[f] = 1'b0;
                    end else if (m_mode == M_UP && !above(m_pend, f)) begin
                        m_mode = M_IDLE;
                    end else if (m_mode == M_DN && !below(m_pend, f)) begin
                        m_mode = M_IDLE;
                    end
                end
            end
            default: begin
                f = m_pos / FPC;
                if (np[f]) begin
                    m_door = DOOR;
                    np[f] = 1'b0;
                end else begin
                    m_door--;
                    if (m_door == 0) m_mode = M_IDLE;
                end
            end
        endcase
        m_pend = np;
    endtask

    task automatic compare_all();
        int ed;
        ed = (m_mode == M_UP) ? 0 : (m_mode == M_DN) ? 1 : 2;
        check("dir", elv1_dir, ed);
        check("floor", cur_floor, m_floor());
        check("door", door_open, m_mode == M_DOOR);
        check("moving", moving, ed < 2);
        check("pending", pending, m_pend);
        check("inv_moving", moving, elv1_dir < 2'd2);
        check("inv_excl", door_open && moving, 0);
    endtask

    task automatic tick(input bit [3:0] c);
        call_req = c;
        @(posedge clk);
        cyc++;
        model_step(c);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        call_req = 4'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_async_dir", elv1_dir, 2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_stops(input int bound, input string tag);
        int n;
        bit prev;
        n = 0;
        prev = door_open;
        stop_q.delete();
        while (!(m_mode == M_IDLE && m_pend == 4'b0) && n < bound) begin
            tick(4'b0);
            if (door_open && !prev) stop_q.push_back(int'(cur_floor));
            prev = door_open;
            n++;
        end
        check({tag, "_drained"}, n < bound, 1);
    endtask

    task automatic ticks_to_door(output int n);
        n = 1;
        while (!door_open && n < 60) begin
            tick(4'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        bit [3:0] c;
        model_reset();
        rst_n = 1'b0;
        call_req = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_pending", pending, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // up trip 0 -> 3
        tick(4'b1000);
        check("t1_latch", pending, 4'b1000);
        tick(4'b0);
        check("t1_dir_up", elv1_dir, 0);
        ticks_to_door(n);
        check("t1_arrive", n, 25);
        check("t1_floor", cur_floor, 3);
        check("t1_pend", pending, 0);
        run_stops(40, "t1");

        // down trip 3 -> 0
        tick(4'b0001);
        tick(4'b0);
        check("t2_dir_dn", elv1_dir, 1);
        ticks_to_door(n);
        check("t2_arrive", n, 25);
        check("t2_floor", cur_floor, 0);
        run_stops(40, "t2");

        // call at current floor, re-press during dwell
        tick(4'b0001);
        tick(4'b0);
        check("t4_door", door_open, 1);
        check("t4_dir", elv1_dir, 2);
        tick(4'b0);
        tick(4'b0);
        tick(4'b0001);
        n = 0;
        while (door_open && n < 20) begin
            tick(4'b0);
            n++;
        end
        check("t4_redwell", n, 5);

        // mid-travel calls ahead and behind
        tick(4'b1000);
        repeat (4) tick(4'b0);
        tick(4'b0100);
        tick(4'b0001);
        run_stops(200, "t3");
        check("t3_nstops", stop_q.size(), 3);
        if (stop_q.size() == 3) begin
            check("t3_stop0", stop_q[0], 2);
            check("t3_stop1", stop_q[1], 3);
            check("t3_stop2", stop_q[2], 0);
        end

        // idle at 1 after an up trip, calls both ways
        tick(4'b0010);
        run_stops(60, "t6a");
        tick(4'b1001);
        tick(4'b0);
        check("t6_dir_up", elv1_dir, 0);
        run_stops(200, "t6");
        check("t6_nstops", stop_q.size(), 2);
        if (stop_q.size() == 2) begin
            check("t6_stop0", stop_q[0], 3);
            check("t6_stop1", stop_q[1], 0);
        end

        // reset mid-travel
        tick(4'b1010);
        repeat (4) tick(4'b0);
        check("t5_pend", pending, 4'b1010);
        check("t5_moving", moving, 1);
        async_reset();
        check("t5_pend_clr", pending, 0);
        repeat (20) tick(4'b0);
        check("t5_still_floor", cur_floor, 0);
        check("t5_still_dir", elv1_dir, 2);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            c = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
            tick(c);
            if ($urandom_range(0, 1499) == 0) async_reset();
        end
        run_stops(400, "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
